// File: rtl/dbg_host_bridge_pkg.sv
// Shared encodings for the b16 debug host bridge: FSM states, command opcodes,
// debug register indices and fixed response bytes.
package dbg_host_bridge_pkg;

  typedef enum logic [3:0] {
    IDLE, GET_HI, GET_LO, WRITE, READ, TX_HI, TX_LO, ERR, TX_ACK
  } state_t;

  typedef enum logic [1:0] {
    CMD_READ  = 2'b00,
    CMD_WRITE = 2'b01,
    CMD_SNAP  = 2'b10,
    CMD_ILL   = 2'b11
  } cmd_t;

  localparam logic [2:0] REG_N    = 3'd0;
  localparam logic [2:0] REG_R    = 3'd1;
  localparam logic [2:0] REG_BP   = 3'd2;
  localparam logic [2:0] REG_STAT = 3'd3;
  localparam logic [2:0] REG_P    = 3'd4;
  localparam logic [2:0] REG_T    = 3'd5;
  localparam logic [2:0] REG_RR   = 3'd6;
  localparam logic [2:0] REG_I    = 3'd7;

  localparam logic [7:0] RSP_ERR = 8'hEE;
  localparam logic [7:0] RSP_ACK = 8'hA5;

  function automatic cmd_t cmd_op(input logic [7:0] b);
    return cmd_t'(b[7:6]);
  endfunction

endpackage

// File: rtl/dbg_host_bridge_tx.sv
// Byte serializer onto the tx valid/ready link: a loaded word goes out hi then lo (pair) or as its lo byte only.
// First byte appears the cycle after load and is held stable until tx_ready; load is only issued while idle.
module dbg_tx_byte (
  input  logic        clk,
  input  logic        nreset,
  input  logic        load,
  input  logic        pair,
  input  logic [15:0] word,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        accept,
  output logic        done
);

  logic [7:0] lo;
  logic       more;

  assign accept = tx_valid & tx_ready;
  assign done   = accept & ~more;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      lo       <= 8'h00;
      more     <= 1'b0;
    end else if (load) begin
      tx_valid <= 1'b1;
      tx_data  <= pair ? word[15:8] : word[7:0];
      lo       <= word[7:0];
      more     <= pair;
    end else if (accept) begin
      if (more) begin
        tx_data <= lo;
        more    <= 1'b0;
      end else begin
        tx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dbg_host_bridge.sv
// Host byte-protocol initiator for the b16 debug window: parses READ/WRITE/SNAPSHOT, strobes r/w, streams reads back.
// Writes strobe one cycle after the lo byte; rx is back-pressured outside IDLE/GET_*; optional write ACK via DBG_ACK_EN.
module dbg_host_bridge
  import dbg_host_bridge_pkg::*;
#(
  parameter int               l       = 16,
  parameter logic [l-5:0]     dbgaddr = 12'hFFE,
  parameter logic [15:0]      tmo     = 16'd50000
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic [l-2:0] addr,
  output logic         r,
  output logic [1:0]   w,
  output logic [l-1:0] data,
  input  logic [l-1:0] din,
  output logic         busy
);

  state_t      state, nxt;
  logic [2:0]  idx;
  logic        snap;
  logic [15:0] gap;
  logic        gap_hit;
  logic        rx_acc;
  cmd_t        op;
  logic        tx_load, tx_pair, tx_accept, tx_done;
  logic [15:0] tx_word;

  assign op       = cmd_op(rx_data);
  assign rx_ready = (state == IDLE) || (state == GET_HI) || (state == GET_LO);
  assign rx_acc   = rx_valid & rx_ready;
  assign gap_hit  = (gap == tmo - 16'd1);

  assign r    = (state == READ);
  assign w    = {2{state == WRITE}};
  assign addr = {dbgaddr, idx};
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!nreset) state <= IDLE;
    else         state <= nxt;
  end

  always_comb begin
    nxt     = state;
    tx_load = 1'b0;
    tx_pair = 1'b0;
    tx_word = din[15:0];
    case (state)
      IDLE: begin
        if (rx_acc) begin
          case (op)
            CMD_READ, CMD_SNAP: nxt = READ;
            CMD_WRITE:          nxt = GET_HI;
            default: begin
              nxt     = ERR;
              tx_load = 1'b1;
              tx_word = {8'h00, RSP_ERR};
            end
          endcase
        end
      end
      GET_HI: begin
        if (rx_acc)       nxt = GET_LO;
        else if (gap_hit) nxt = IDLE;
      end
      GET_LO: begin
        if (rx_acc)       nxt = WRITE;
        else if (gap_hit) nxt = IDLE;
      end
      WRITE: begin
`ifdef DBG_ACK_EN
        nxt     = TX_ACK;
        tx_load = 1'b1;
        tx_word = {8'h00, RSP_ACK};
`else
        nxt = IDLE;
`endif
      end
      // din is sampled into the serializer in the same cycle as the r strobe
      READ: begin
        nxt     = TX_HI;
        tx_load = 1'b1;
        tx_pair = 1'b1;
      end
      TX_HI: if (tx_accept) nxt = TX_LO;
      TX_LO: if (tx_done)   nxt = (snap && idx != REG_I) ? READ : IDLE;
      ERR, TX_ACK: if (tx_done) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      idx  <= 3'd0;
      snap <= 1'b0;
      data <= '0;
      gap  <= 16'd0;
    end else begin
      if (state == IDLE && rx_acc && op != CMD_ILL) begin
        snap <= (op == CMD_SNAP);
        // snapshot starts at BP: reading N or R would pop the cpu stacks
        idx  <= (op == CMD_SNAP) ? REG_BP : rx_data[2:0];
      end
      if (state == GET_HI && rx_acc) data[l-1:8] <= rx_data;
      if (state == GET_LO && rx_acc) data[7:0]   <= rx_data;
      if (state == TX_LO && tx_done && nxt == READ) idx <= idx + 3'd1;
      if ((state == GET_HI || state == GET_LO) && !rx_acc && !gap_hit) gap <= gap + 16'd1;
      else                                                               gap <= 16'd0;
    end
  end

  dbg_tx_byte u_tx (
    .clk      (clk),
    .nreset   (nreset),
    .load     (tx_load),
    .pair     (tx_pair),
    .word     (tx_word),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .accept   (tx_accept),
    .done     (tx_done)
  );

endmodule
